// File: rtl/afe_seq_pkg.sv
// afe_seq_pkg: shared states, control-mode and diagnostic-result codes for the AFE frame sequencer
package afe_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIAG_RD,
        S_DIAG_DONE,
        S_WAIT_DN,
        S_CH_RD,
        S_COMMIT
    } state_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_DIAG = 2'b01;
    localparam logic [1:0] CTRL_STRM = 2'b10;

    localparam logic [1:0] DIAG_PEND = 2'b00;
    localparam logic [1:0] DIAG_OK   = 2'b10;
    localparam logic [1:0] DIAG_ERR  = 2'b01;

    // Control mode a state belongs to; a mismatch with the live control aborts to idle
    function automatic logic [1:0] state_mode(state_t s);
        return (s == S_DIAG_RD || s == S_DIAG_DONE) ? CTRL_DIAG :
               (s == S_IDLE) ? CTRL_IDLE : CTRL_STRM;
    endfunction

    // The reserved control code behaves exactly like idle
    function automatic logic [1:0] ctrl_mode(logic [1:0] c);
        return (c == CTRL_DIAG || c == CTRL_STRM) ? c : CTRL_IDLE;
    endfunction

endpackage

// File: rtl/afe_rd_timer.sv
// afe_rd_timer: loadable down-counter that strobes fire on the cycle read data becomes valid
module afe_rd_timer #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic fire
);

    logic [2:0] cnt;
    logic       busy;

    assign fire = busy && cnt == '0;

    // Count down from LAT after each address change; fire marks the capture edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= 3'(LAT);
        end else if (fire) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - 3'd1;
        end
    end

endmodule

// File: rtl/afe_frame_sequencer.sv
// afe_frame_sequencer: reads AFE readout RAM channels into a coherent frame and runs the diagnostic check
module afe_frame_sequencer
    import afe_seq_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int SAMP_W     = 22,
    parameter int IN_W       = 24,
    parameter int ADDR_W     = 3,
    parameter int BASE_ADDR  = 0,
    parameter int DIAG_ADDR  = 6,
    parameter int ER_W       = 14,
    parameter int RD_LAT     = 1,
    parameter int OFFSET_BIN = 0
) (
    input  logic                     clk,
    input  logic                     in_reset_n,
    input  logic [1:0]               in_data_control,
    input  logic                     in_strm_dn,
    input  logic [IN_W-1:0]          in_strm_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [NUM_CH*SAMP_W-1:0] out_samples,
    output logic                     out_new_samples,
    output logic [15:0]              out_frame_cnt,
    output logic                     out_overrun,
    output logic [1:0]               out_diag_er,
    output logic [ER_W-1:0]          out_er_data
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] DIAG     = ADDR_W'(DIAG_ADDR);
    localparam logic [SAMP_W-1:0] MSB_FLIP = (OFFSET_BIN != 0) ? SAMP_W'(1) << (SAMP_W - 1) : '0;

    if (BASE_ADDR + NUM_CH - 1 >= (1 << ADDR_W) || DIAG_ADDR >= (1 << ADDR_W)) begin : g_addr_chk
        $error("afe_frame_sequencer: channel or diagnostic address does not fit in ADDR_W");
    end
    if (NUM_CH < 1 || NUM_CH > 8 || RD_LAT < 0 || RD_LAT > 7) begin : g_range_chk
        $error("afe_frame_sequencer: NUM_CH or RD_LAT out of range");
    end

    state_t                     state;
    logic [1:0]                 mode;
    logic                       abort;
    logic                       last;
    logic                       fire;
    logic                       tmr_load;
    logic [2:0]                 k;
    logic [SAMP_W-1:0]          fmt;
    logic [NUM_CH*SAMP_W-1:0]   shadow;
    logic [NUM_CH*SAMP_W-1:0]   frame_next;
    logic                       unused_data;

    assign unused_data = ^in_strm_data;

    // Mode decode, capture formatting and the shadow image with slot k replaced by the incoming sample
    always_comb begin
        mode       = ctrl_mode(in_data_control);
        abort      = state != S_IDLE && mode != state_mode(state);
        last       = k == 3'(NUM_CH - 1);
        fmt        = in_strm_data[SAMP_W-1:0] ^ MSB_FLIP;
        tmr_load   = !abort && ((state == S_IDLE && mode == CTRL_DIAG) ||
                                (state == S_WAIT_DN && in_strm_dn) ||
                                (state == S_CH_RD && fire && !last));
        frame_next = shadow;
        for (int i = 0; i < NUM_CH; i++)
            if (k == 3'(i)) frame_next[i*SAMP_W +: SAMP_W] = fmt;
    end

    afe_rd_timer #(.LAT(RD_LAT)) u_timer (
        .clk   (clk),
        .rst_n (in_reset_n),
        .load  (tmr_load),
        .clear (abort),
        .fire  (fire)
    );

    // Sequencer: idle/abort clears everything; the last channel capture publishes the whole frame at once
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state           <= S_IDLE;
            out_addr        <= '0;
            out_samples     <= '0;
            out_new_samples <= 1'b0;
            out_frame_cnt   <= '0;
            out_overrun     <= 1'b0;
            out_diag_er     <= DIAG_PEND;
            out_er_data     <= '0;
            shadow          <= '0;
            k               <= '0;
        end else if (abort || state == S_IDLE) begin
            state           <= abort ? S_IDLE : mode == CTRL_DIAG ? S_DIAG_RD :
                               mode == CTRL_STRM ? S_WAIT_DN : S_IDLE;
            out_addr        <= abort ? '0 : mode == CTRL_DIAG ? DIAG : mode == CTRL_STRM ? BASE : '0;
            out_samples     <= '0;
            out_new_samples <= 1'b0;
            out_frame_cnt   <= '0;
            out_overrun     <= 1'b0;
            out_diag_er     <= DIAG_PEND;
            out_er_data     <= '0;
            shadow          <= '0;
            k               <= '0;
        end else begin
            case (state)
                S_DIAG_RD: if (fire) begin
                    out_er_data <= in_strm_data[ER_W-1:0];
                    state       <= S_DIAG_DONE;
                end
                S_DIAG_DONE: out_diag_er <= (out_er_data == '0) ? DIAG_OK : DIAG_ERR;
                S_WAIT_DN: if (in_strm_dn) begin
                    state <= S_CH_RD;
                    k     <= '0;
                end
                S_CH_RD: begin
                    if (in_strm_dn) out_overrun <= 1'b1;
                    if (fire) begin
                        shadow   <= frame_next;
                        k        <= last ? '0 : k + 3'd1;
                        out_addr <= last ? BASE : out_addr + ADDR_W'(1);
                        if (last) begin
                            out_samples     <= frame_next;
                            out_new_samples <= 1'b1;
                            out_frame_cnt   <= out_frame_cnt + 16'd1;
                            state           <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    if (in_strm_dn) out_overrun <= 1'b1;
                    out_new_samples <= 1'b0;
                    state           <= S_WAIT_DN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afe_frame_sequencer.sv
// tb_afe_frame_sequencer: directed vectors for a default instance and a 2-channel/RD_LAT=3/offset-binary instance
module tb_afe_frame_sequencer;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [23:0] r6;
        logic [2:0]  addr;
        logic [1:0]  de;
        logic [13:0] er;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   ctrl;
    logic         dn;
    logic [23:0]  ram1 [8];
    logic [23:0]  ram2 [8];
    logic [2:0]   a1;
    logic [2:0]   p2 [3];
    logic [23:0]  data1, data2;
    logic [2:0]   addr1, addr2;
    logic [131:0] smp1;
    logic [43:0]  smp2;
    logic         new1, new2, ov1, ov2;
    logic [15:0]  fc1, fc2;
    logic [1:0]   de1, de2;
    logic [13:0]  er1, er2;
    logic [131:0] exp1;
    vec_t         tbl [23];
    int           n_vec = 0;
    int           n_bad = 0;
    int           l1, l2, c1, c2;

    always #5 clk = ~clk;

    // Readout RAM models: data follows the address RD_LAT cycles later
    always @(posedge clk) begin
        a1    <= addr1;
        p2[0] <= addr2;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign data1 = ram1[a1];
    assign data2 = ram2[p2[2]];

    afe_frame_sequencer dut (
        .clk             (clk),
        .in_reset_n      (rst_n),
        .in_data_control (ctrl),
        .in_strm_dn      (dn),
        .in_strm_data    (data1),
        .out_addr        (addr1),
        .out_samples     (smp1),
        .out_new_samples (new1),
        .out_frame_cnt   (fc1),
        .out_overrun     (ov1),
        .out_diag_er     (de1),
        .out_er_data     (er1)
    );

    afe_frame_sequencer #(.NUM_CH(2), .RD_LAT(3), .OFFSET_BIN(1)) dut2 (
        .clk             (clk),
        .in_reset_n      (rst_n),
        .in_data_control (ctrl),
        .in_strm_dn      (dn),
        .in_strm_data    (data2),
        .out_addr        (addr2),
        .out_samples     (smp2),
        .out_new_samples (new2),
        .out_frame_cnt   (fc2),
        .out_overrun     (ov2),
        .out_diag_er     (de2),
        .out_er_data     (er2)
    );

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles with strobes sampled on steps s1 and s2 (0 = none); report first pulse step and pulse counts
    task automatic frame(input int n, input int s1, input int s2,
                         output int f1, output int f2, output int k1, output int k2);
        f1 = 0; f2 = 0; k1 = 0; k2 = 0;
        for (int i = 1; i <= n; i++) begin
            dn = (i == s1 || i == s2);
            step();
            dn = 1'b0;
            if (new1) begin k1++; if (f1 == 0) f1 = i; end
            if (new2) begin k2++; if (f2 == 0) f2 = i; end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ram1[i] = 24'h100 + 24'(i);
            ram2[i] = 24'h3FFFFF;
        end
        ram1[6] = 24'h0;
        ram2[0] = 24'h200000;
        ram2[1] = 24'hC12345;
        for (int i = 0; i < 6; i++) exp1[i*22 +: 22] = 22'h100 + 22'(i);

        tbl = '{
            '{2'b01, 24'h000000, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h000000, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h000000, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h000000, 3'd6, 2'b10, 14'h0000},
            '{2'b01, 24'h000000, 3'd6, 2'b10, 14'h0000},
            '{2'b00, 24'h000004, 3'd0, 2'b00, 14'h0000},
            '{2'b01, 24'h000004, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h000004, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h000004, 3'd6, 2'b00, 14'h0004},
            '{2'b01, 24'h000004, 3'd6, 2'b01, 14'h0004},
            '{2'b10, 24'h000004, 3'd0, 2'b00, 14'h0000},
            '{2'b10, 24'h000004, 3'd0, 2'b00, 14'h0000},
            '{2'b01, 24'h000004, 3'd0, 2'b00, 14'h0000},
            '{2'b01, 24'hFFC000, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'hFFC000, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'hFFC000, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'hFFC000, 3'd6, 2'b10, 14'h0000},
            '{2'b11, 24'h003FFF, 3'd0, 2'b00, 14'h0000},
            '{2'b01, 24'h003FFF, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h003FFF, 3'd6, 2'b00, 14'h0000},
            '{2'b01, 24'h003FFF, 3'd6, 2'b00, 14'h3FFF},
            '{2'b01, 24'h003FFF, 3'd6, 2'b01, 14'h3FFF},
            '{2'b00, 24'h003FFF, 3'd0, 2'b00, 14'h0000}
        };

        rst_n = 1'b0;
        ctrl  = 2'b00;
        dn    = 1'b0;
        repeat (2) step();
        chk("reset dut", {addr1, smp1, new1, fc1, ov1, de1, er1}, '0);
        chk("reset dut2", {addr2, smp2, new2, fc2, ov2, de2, er2}, '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 23; i++) begin
            ctrl    = tbl[i].ctrl;
            ram1[6] = tbl[i].r6;
            step();
            chk($sformatf("diag vec %0d", i), {addr1, de1, er1, new1},
                {tbl[i].addr, tbl[i].de, tbl[i].er, 1'b0});
        end

        ctrl = 2'b10;
        step();
        frame(20, 1, 0, l1, l2, c1, c2);
        chk("frame latency", l1, 13);
        chk("frame pulses", c1, 1);
        chk("frame samples", smp1, exp1);
        chk("frame count", fc1, 1);
        chk("frame overrun", ov1, 0);
        chk("lat3 latency", l2, 9);
        chk("lat3 pulses", c2, 1);
        chk("lat3 samples", smp2, {22'h212345, 22'h000000});
        chk("lat3 count", fc2, 1);
        step();
        chk("pulse width", {new1, new2}, 2'b00);

        frame(30, 1, 15, l1, l2, c1, c2);
        chk("b2b pulses", c1, 2);
        chk("b2b overrun", ov1, 0);
        chk("b2b count", fc1, 3);
        chk("lat3 b2b pulses", c2, 2);
        chk("lat3 b2b count", fc2, 3);

        frame(20, 1, 14, l1, l2, c1, c2);
        chk("commit strobe pulses", c1, 1);
        chk("commit strobe overrun", ov1, 1);
        chk("commit strobe count", fc1, 4);

        ctrl = 2'b00;
        step();
        chk("idle clear", {addr1, smp1, new1, fc1, ov1, de1, er1}, '0);

        ctrl = 2'b10;
        step();
        frame(20, 1, 6, l1, l2, c1, c2);
        chk("overrun pulses", c1, 1);
        chk("overrun flag", ov1, 1);
        chk("overrun count", fc1, 1);
        ctrl = 2'b00;
        step();
        chk("overrun clear", {addr1, smp1, new1, fc1, ov1, de1, er1}, '0);

        ctrl = 2'b10;
        step();
        frame(5, 1, 0, l1, l2, c1, c2);
        ctrl = 2'b00;
        step();
        ctrl = 2'b10;
        step();
        frame(20, 0, 0, l1, l2, c1, c2);
        chk("abort no pulse", c1, 0);
        chk("abort samples", smp1, '0);
        frame(20, 1, 0, l1, l2, c1, c2);
        chk("after abort latency", l1, 13);
        chk("after abort samples", smp1, exp1);
        chk("after abort count", fc1, 1);

        frame(4, 1, 0, l1, l2, c1, c2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset dut", {addr1, smp1, new1, fc1, ov1, de1, er1}, '0);
        chk("async reset dut2", {addr2, smp2, new2, fc2, ov2, de2, er2}, '0);
        #1 rst_n = 1'b1;
        step();
        frame(20, 0, 0, l1, l2, c1, c2);
        chk("post reset pulses", c1 + c2, 0);
        chk("post reset state", {smp1, fc1, ov1}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
